// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port SRAM between the display
// fetch path (absolute priority) and a CPU/host port. The memory command is
// registered, and 1-cycle-latency read data is steered back to its requester.
// A sticky flag reports CPU starvation.
// Optional feature macro: VRAM_ARB_BLANK_ONLY_EN. When it is defined, the CPU
// is only granted during horizontal or vertical blank (tear-free mode).
module vram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hblank,
  input  logic              i_vblank,
  input  logic              i_disp_valid,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_ready,
  output logic              o_disp_rvalid,
  output logic [DATA_W-1:0] o_disp_rdata,
  input  logic              i_cpu_valid,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_ready,
  output logic              o_cpu_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_starved,
  input  logic              i_starve_clr,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, DISP, CPU_RD, CPU_WR} issue_t;

  localparam logic [15:0] WAIT_LIM = 16'(MAX_WAIT);

  issue_t      issue_q, issue_d, owner_q;
  logic        cpu_window;
  logic        in_blank;
  logic        cpu_wait;
  logic [15:0] wait_cnt, wait_nx;

  assign in_blank = i_hblank | i_vblank;

`ifdef VRAM_ARB_BLANK_ONLY_EN
  assign cpu_window = in_blank;
`else
  // Blank inputs have no effect here; OR-ing them in keeps them connected.
  assign cpu_window = 1'b1 | in_blank;
`endif

  assign o_disp_ready = i_disp_valid;
  assign o_cpu_ready  = i_cpu_valid & ~i_disp_valid & cpu_window;

  // Next issue state from this cycle's grant; display always wins.
  always_comb begin
    issue_d = IDLE;
    if (i_disp_valid)     issue_d = DISP;
    else if (o_cpu_ready) issue_d = i_cpu_we ? CPU_WR : CPU_RD;
  end

  // Issue and owner registers: owner trails issue to tag the returning data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      issue_q <= IDLE;
      owner_q <= IDLE;
    end else begin
      issue_q <= issue_d;
      owner_q <= issue_q;
    end
  end

  // Capture address/wdata from the winner; hold them when nobody is granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else if (i_disp_valid) begin
      o_mem_addr  <= i_disp_addr;
    end else if (o_cpu_ready) begin
      o_mem_addr  <= i_cpu_addr;
      o_mem_wdata <= i_cpu_wdata;
    end
  end

  assign o_mem_en = (issue_q != IDLE);
  assign o_mem_we = (issue_q == CPU_WR);

  assign o_disp_rvalid = (owner_q == DISP);
  assign o_cpu_rvalid  = (owner_q == CPU_RD);
  assign o_disp_rdata  = i_mem_rdata;
  assign o_cpu_rdata   = i_mem_rdata;

  assign cpu_wait = i_cpu_valid & ~o_cpu_ready;
  assign wait_nx  = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  // Saturating wait counter; any transfer or dropped request restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      wait_cnt <= '0;
    else if (cpu_wait) wait_cnt <= wait_nx;
    else               wait_cnt <= '0;
  end

  // Sticky starvation flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             o_cpu_starved <= 1'b0;
    else if (cpu_wait && wait_nx >= WAIT_LIM) o_cpu_starved <= 1'b1;
    else if (i_starve_clr)                    o_cpu_starved <= 1'b0;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Table-driven bench for vram_arbiter with a behavioural SRAM model
// (unwritten words read back as addr[7:0]).
module tb_vram_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_hblank, i_vblank;
  logic        i_disp_valid;
  logic [15:0] i_disp_addr;
  logic        o_disp_ready, o_disp_rvalid;
  logic [7:0]  o_disp_rdata;
  logic        i_cpu_valid, i_cpu_we;
  logic [15:0] i_cpu_addr;
  logic [7:0]  i_cpu_wdata;
  logic        o_cpu_ready, o_cpu_rvalid;
  logic [7:0]  o_cpu_rdata;
  logic        o_cpu_starved, i_starve_clr;
  logic        o_mem_en, o_mem_we;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic [7:0]  i_mem_rdata;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hblank(i_hblank), .i_vblank(i_vblank),
    .i_disp_valid(i_disp_valid), .i_disp_addr(i_disp_addr),
    .o_disp_ready(o_disp_ready), .o_disp_rvalid(o_disp_rvalid),
    .o_disp_rdata(o_disp_rdata), .i_cpu_valid(i_cpu_valid), .i_cpu_we(i_cpu_we),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata), .o_cpu_ready(o_cpu_ready),
    .o_cpu_rvalid(o_cpu_rvalid), .o_cpu_rdata(o_cpu_rdata),
    .o_cpu_starved(o_cpu_starved), .i_starve_clr(i_starve_clr),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous SRAM model, 1-cycle read latency.
  logic [7:0] mem [0:65535];
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a);
    i_mem_rdata = 8'h00;
  end
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          i_mem_rdata     <= mem[o_mem_addr];
    end
  end

  typedef struct {
    logic        dv;  logic [15:0] da;
    logic        cv;  logic cwe; logic [15:0] ca;
    logic        e_dr, e_cr, e_en, e_we;
    logic [15:0] e_addr;
    logic        e_drv, e_crv;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t v(logic dv, logic [15:0] da, logic cv, logic cwe,
                             logic [15:0] ca, logic dr, logic cr, logic en,
                             logic we, logic [15:0] addr, logic drv, logic crv,
                             logic [7:0] rd);
    vec_t r;
    r.dv = dv; r.da = da; r.cv = cv; r.cwe = cwe; r.ca = ca;
    r.e_dr = dr; r.e_cr = cr; r.e_en = en; r.e_we = we; r.e_addr = addr;
    r.e_drv = drv; r.e_crv = crv; r.e_rd = rd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic [15:0] da, input logic cv,
                       input logic cwe, input logic [15:0] ca, input logic [7:0] wd);
    i_disp_valid = dv; i_disp_addr = da;
    i_cpu_valid = cv; i_cpu_we = cwe; i_cpu_addr = ca; i_cpu_wdata = wd;
  endtask

  initial begin
    i_rst_n = 1'b0; i_hblank = 1'b1; i_vblank = 1'b0; i_starve_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mem_en", o_mem_en, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_rvalid", {o_disp_rvalid, o_cpu_rvalid}, 0);
    chk("rst_starved", o_cpu_starved, 0);
    tick; tick;
    i_rst_n = 1'b1;

    // Display stream, contention, and interleaved reads.
    tbl[0]  = v(1, 0, 0, 0, 0,       1, 0, 0, 0, 0,     0, 0, 0);
    tbl[1]  = v(1, 1, 0, 0, 0,       1, 0, 1, 0, 0,     0, 0, 0);
    tbl[2]  = v(1, 2, 0, 0, 0,       1, 0, 1, 0, 1,     1, 0, 8'h00);
    tbl[3]  = v(1, 3, 0, 0, 0,       1, 0, 1, 0, 2,     1, 0, 8'h01);
    tbl[4]  = v(0, 0, 0, 0, 0,       0, 0, 1, 0, 3,     1, 0, 8'h02);
    tbl[5]  = v(0, 0, 0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 8'h03);
    tbl[6]  = v(0, 0, 0, 0, 0,       0, 0, 0, 0, 0,     0, 0, 0);
    tbl[7]  = v(1, 16'h10, 1, 0, 16'h20, 1, 0, 0, 0, 0,      0, 0, 0);
    tbl[8]  = v(1, 16'h10, 1, 0, 16'h20, 1, 0, 1, 0, 16'h10, 0, 0, 0);
    tbl[9]  = v(1, 16'h10, 1, 0, 16'h20, 1, 0, 1, 0, 16'h10, 1, 0, 8'h10);
    tbl[10] = v(1, 16'h10, 1, 0, 16'h20, 1, 0, 1, 0, 16'h10, 1, 0, 8'h10);
    tbl[11] = v(1, 16'h10, 1, 0, 16'h20, 1, 0, 1, 0, 16'h10, 1, 0, 8'h10);
    tbl[12] = v(0, 0, 1, 0, 16'h20,  0, 1, 1, 0, 16'h10, 1, 0, 8'h10);
    tbl[13] = v(0, 0, 0, 0, 0,       0, 0, 1, 0, 16'h20, 1, 0, 8'h10);
    tbl[14] = v(0, 0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 1, 8'h20);
    tbl[15] = v(0, 0, 0, 0, 0,       0, 0, 0, 0, 0,      0, 0, 0);
    tbl[16] = v(1, 5, 0, 0, 0,       1, 0, 0, 0, 0,     0, 0, 0);
    tbl[17] = v(0, 0, 1, 0, 6,       0, 1, 1, 0, 5,     0, 0, 0);
    tbl[18] = v(1, 7, 0, 0, 0,       1, 0, 1, 0, 6,     1, 0, 8'h05);
    tbl[19] = v(0, 0, 0, 0, 0,       0, 0, 1, 0, 7,     0, 1, 8'h06);
    tbl[20] = v(0, 0, 0, 0, 0,       0, 0, 0, 0, 0,     1, 0, 8'h07);
    tbl[21] = v(0, 0, 0, 0, 0,       0, 0, 0, 0, 0,     0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      tick;
      drive(tbl[i].dv, tbl[i].da, tbl[i].cv, tbl[i].cwe, tbl[i].ca, 8'h00);
      #1;
      chk($sformatf("v%0d_disp_ready", i), o_disp_ready, tbl[i].e_dr);
      chk($sformatf("v%0d_cpu_ready", i), o_cpu_ready, tbl[i].e_cr);
      chk($sformatf("v%0d_mem_en", i), o_mem_en, tbl[i].e_en);
      chk($sformatf("v%0d_mem_we", i), o_mem_we, tbl[i].e_we);
      if (tbl[i].e_en) chk($sformatf("v%0d_mem_addr", i), o_mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_disp_rvalid", i), o_disp_rvalid, tbl[i].e_drv);
      chk($sformatf("v%0d_cpu_rvalid", i), o_cpu_rvalid, tbl[i].e_crv);
      if (tbl[i].e_drv) chk($sformatf("v%0d_disp_rdata", i), o_disp_rdata, tbl[i].e_rd);
      if (tbl[i].e_crv) chk($sformatf("v%0d_cpu_rdata", i), o_cpu_rdata, tbl[i].e_rd);
      chk($sformatf("v%0d_starved", i), o_cpu_starved, 0);
    end

    // CPU write followed by a read of the same word.
    tick; drive(0, 0, 1, 1, 16'h1234, 8'hA5); #1;
    chk("wr_ready", o_cpu_ready, 1);
    tick; drive(0, 0, 1, 0, 16'h1234, 8'h00); #1;
    chk("rd_ready", o_cpu_ready, 1);
    chk("wr_cmd", {o_mem_en, o_mem_we}, 2'b11);
    chk("wr_addr", o_mem_addr, 16'h1234);
    chk("wr_wdata", o_mem_wdata, 8'hA5);
    tick; drive(0, 0, 0, 0, 0, 0); #1;
    chk("rd_cmd", {o_mem_en, o_mem_we}, 2'b10);
    chk("wr_no_rvalid", {o_disp_rvalid, o_cpu_rvalid}, 0);
    tick; #1;
    chk("rd_rvalid", o_cpu_rvalid, 1);
    chk("rd_rdata", o_cpu_rdata, 8'hA5);
    chk("rd_mem_en", o_mem_en, 0);

    // Starvation with MAX_WAIT=8 under continuous display traffic.
    for (int k = 1; k <= 12; k++) begin
      tick; drive(1, 16'h50, 1, 0, 16'h60, 0); #1;
      chk($sformatf("starve_k%0d", k), o_cpu_starved, (k >= 9));
      chk($sformatf("starve_rdy_k%0d", k), o_cpu_ready, 0);
    end
    tick; drive(0, 0, 0, 0, 0, 0); #1;
    chk("starve_hold1", o_cpu_starved, 1);
    tick; #1;
    chk("starve_hold2", o_cpu_starved, 1);
    tick; i_starve_clr = 1'b1; #1;
    chk("starve_clr_pending", o_cpu_starved, 1);
    tick; i_starve_clr = 1'b0; #1;
    chk("starve_cleared", o_cpu_starved, 0);

    // Reset with two display reads in flight.
    tick; drive(1, 16'h40, 0, 0, 0, 0);
    tick; drive(1, 16'h41, 0, 0, 0, 0);
    tick; drive(0, 0, 0, 0, 0, 0); #1;
    chk("pre_rst_en", o_mem_en, 1);
    chk("pre_rst_rvalid", o_disp_rvalid, 1);
    i_rst_n = 1'b0; #1;
    chk("arst_mem", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata}, 0);
    chk("arst_rvalid", {o_disp_rvalid, o_cpu_rvalid, o_cpu_starved}, 0);
    tick; tick;
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick; #1;
      chk($sformatf("post_rst_rvalid%0d", k), {o_disp_rvalid, o_cpu_rvalid}, 0);
      chk($sformatf("post_rst_en%0d", k), o_mem_en, 0);
    end

    // CPU window relative to the visible region.
    tick; i_hblank = 1'b0; i_vblank = 1'b0; drive(0, 0, 1, 0, 16'h77, 0); #1;
`ifdef VRAM_ARB_BLANK_ONLY_EN
    chk("visible_no_grant", o_cpu_ready, 0);
    i_hblank = 1'b1; #1;
    chk("hblank_grant", o_cpu_ready, 1);
`else
    chk("visible_grant", o_cpu_ready, 1);
`endif
    tick; drive(0, 0, 0, 0, 0, 0); #1;
    chk("win_cmd", o_mem_en, 1);
    tick; #1;
    chk("win_rvalid", o_cpu_rvalid, 1);
    chk("win_rdata", o_cpu_rdata, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
